// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//   in_valid/in_data/in_ready : byte stream handshake (source -> loader)
//   imem_we/imem_addr/imem_wdata : word write port (loader -> memory)
// slave modport is the loader's view; master is the environment's view.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream (4-byte big-endian word
// count N, then N big-endian words), writes the words to consecutive word
// addresses from BASE_ADDR and holds the core in reset until loading is done.
// Optional IMEM_LOADER_CHECKSUM_EN: a trailing checksum word must equal the
// XOR of all data words, otherwise the session ends in ERROR.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : pulse, begins a session from IDLE/DONE/ERROR
//   bus (slave)  : byte stream in, instruction-memory write port out
//   cpu_rst_n    : active-low core reset, high only while DONE
//   busy/done/error : session status
//   words_loaded : words written in the current session
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_rst_n,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] words_loaded
);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        LOAD   = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
        , CHECK = 3'd5
`endif
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        byte_cnt;
    logic [23:0]       shreg;
    logic [CNT_W-1:0]  word_count;
    logic              accept;
    logic              word_full;
    logic [31:0]       word;
    logic              session_start;
    logic              write_word;
    logic              hdr_take;
    logic              active_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       xor_acc;
`endif

    // Byte acceptance and word assembly (first byte ends up in [31:24]).
    assign accept    = bus.in_valid && bus.in_ready;
    assign word_full = accept && (byte_cnt == 2'd3);
    assign word      = {shreg, bus.in_data};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next    = state;
        session_start = 1'b0;
        write_word    = 1'b0;
        hdr_take      = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next    = HEADER;
                    session_start = 1'b1;
                end
            end
            HEADER: begin
                if (word_full) begin
                    hdr_take = 1'b1;
                    if ({1'b0, word} > DEPTH) begin
                        state_next = ERROR;
                    end else if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = DONE;
`endif
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_full) begin
                    write_word = 1'b1;
                    if (words_loaded + CNT_W'(1) == word_count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = DONE;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (word_full) begin
                    state_next = (word == xor_acc) ? DONE : ERROR;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign active_next = (state_next == HEADER) || (state_next == LOAD) ||
                         (state_next == CHECK);
`else
    assign active_next = (state_next == HEADER) || (state_next == LOAD);
`endif

    // Datapath and registered outputs; status follows the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= 32'd0;
            cpu_rst_n      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            words_loaded   <= '0;
            byte_cnt       <= 2'd0;
            shreg          <= 24'd0;
            word_count     <= '0;
        end else begin
            bus.imem_we  <= write_word;
            bus.in_ready <= active_next;
            busy         <= active_next;
            done         <= (state_next == DONE);
            error        <= (state_next == ERROR);
            // Released only after a full cycle in DONE, dropped as soon as a restart is seen.
            cpu_rst_n    <= (state == DONE) && (state_next == DONE);
            if (write_word) begin
                bus.imem_wdata <= word;
                bus.imem_addr  <= BASE_ADDR + 32'({words_loaded, 2'b00});
                words_loaded   <= words_loaded + CNT_W'(1);
            end
            if (hdr_take) begin
                word_count <= CNT_W'(word);
            end
            if (session_start) begin
                words_loaded <= '0;
                byte_cnt     <= 2'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= word[23:0];
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of the data words written this session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_acc <= 32'd0;
        end else if (session_start) begin
            xor_acc <= 32'd0;
        end else if (write_word) begin
            xor_acc <= xor_acc ^ word;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images plus randomized
// images with random handshake gaps, checked against a word-level model.
module tb_imem_loader;
    localparam int unsigned ADDR_WIDTH = 8;
    localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                cpu_rst_n;
    logic                busy;
    logic                done;
    logic                error;
    logic [ADDR_WIDTH:0] words_loaded;

    imem_loader_if bus ();

    imem_loader #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .cpu_rst_n   (cpu_rst_n),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int viol     = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    // Write log and continuous invariants (core out of reset only when done).
    always @(negedge clk) begin
        if (bus.imem_we) begin
            got_addr.push_back(bus.imem_addr);
            got_data.push_back(bus.imem_wdata);
        end
        if (cpu_rst_n && !done) viol++;
        if (bus.in_ready && !busy) viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Drive a byte list; gap 0 = back-to-back, 1 = one idle cycle per byte, 2 = random.
    task automatic send_bytes(input logic [7:0] q[$], input int gap, input int poke);
        for (int i = 0; i < q.size(); i++) begin
            bit rdy;
            int n;
            int idle;
            idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < idle; j++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = q[i];
            if (i == poke) start = 1'b1;
            rdy = 1'b0;
            n = 0;
            while (!rdy && n < 100) begin
                @(negedge clk);
                rdy = bus.in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                n++;
            end
            if (!rdy) begin
                n_checks++;
                $display("FAIL byte_accept: byte %0d got in_ready=0 expected acceptance within 100 cycles", i);
                return;
            end
        end
        if (gap == 0) bus.in_data = 8'($urandom);
        else          bus.in_valid = 1'b0;
    endtask

    task automatic begin_session(input string name);
        bus.in_valid = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, error, cpu_rst_n, bus.in_ready} !== 5'b10001)
            $display("FAIL %s_start_status: got busy/done/error/cpu_rst_n/in_ready=%b expected 10001", name,
                     {busy, done, error, cpu_rst_n, bus.in_ready});
        else n_pass++;
        n_checks++;
        if (words_loaded !== '0)
            $display("FAIL %s_start_count: got %0d expected 0", name, words_loaded);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    // Run a whole session and compare with the word-level model.
    task automatic run_image(input string name, input logic [31:0] n_hdr, input logic [31:0] words[$],
                             input int gap, input logic [31:0] csum_delta, input int poke);
        logic [7:0]  q[$];
        logic [31:0] x;
        int          base, v0, k, exp_n;
        bit          exp_err;
        base    = got_addr.size();
        v0      = viol;
        x       = 32'd0;
        exp_err = (n_hdr > 32'(DEPTH));
        exp_n   = exp_err ? 0 : int'(n_hdr);
        begin_session(name);
        for (int b = 0; b < 4; b++) q.push_back(8'(n_hdr >> (24 - 8 * b)));
        if (!exp_err) begin
            for (int i = 0; i < exp_n; i++) begin
                for (int b = 0; b < 4; b++) q.push_back(8'(words[i] >> (24 - 8 * b)));
                x = x ^ words[i];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            x = x + csum_delta;
            for (int b = 0; b < 4; b++) q.push_back(8'(x >> (24 - 8 * b)));
            exp_err = (csum_delta != 32'd0);
`else
            if (csum_delta != 32'd0) begin
                n_checks++;
                $display("FAIL %s_config: got checksum delta %0h expected 0 without checksum build", name, csum_delta);
            end
`endif
        end
        send_bytes(q, gap, poke);
        k = 0;
        while (!(done || error) && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 50) $display("FAIL %s_finish: got no done/error expected end of session within 50 cycles", name);
        else n_pass++;
        n_checks++;
        if ({done, error, cpu_rst_n, busy, bus.in_ready} !== {!exp_err, exp_err, 3'b000})
            $display("FAIL %s_entry: got done/error/cpu_rst_n/busy/in_ready=%b expected %b", name,
                     {done, error, cpu_rst_n, busy, bus.in_ready}, {!exp_err, exp_err, 3'b000});
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({done, error, cpu_rst_n, bus.in_ready} !== {!exp_err, exp_err, !exp_err, 1'b0})
            $display("FAIL %s_settled: got done/error/cpu_rst_n/in_ready=%b expected %b", name,
                     {done, error, cpu_rst_n, bus.in_ready}, {!exp_err, exp_err, !exp_err, 1'b0});
        else n_pass++;
        n_checks++;
        if (int'(words_loaded) !== exp_n)
            $display("FAIL %s_words_loaded: got %0d expected %0d", name, words_loaded, exp_n);
        else n_pass++;
        n_checks++;
        if (got_addr.size() - base !== exp_n)
            $display("FAIL %s_write_count: got %0d expected %0d", name, got_addr.size() - base, exp_n);
        else n_pass++;
        for (int i = 0; i < exp_n && base + i < got_addr.size(); i++) begin
            n_checks++;
            if (got_addr[base + i] !== BASE_ADDR + 32'(4 * i) || got_data[base + i] !== words[i])
                $display("FAIL %s_write%0d: got addr %h data %h expected addr %h data %h", name, i,
                         got_addr[base + i], got_data[base + i], BASE_ADDR + 32'(4 * i), words[i]);
            else n_pass++;
        end
        n_checks++;
        if (viol !== v0) $display("FAIL %s_invariant: got %0d violations expected 0", name, viol - v0);
        else n_pass++;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.imem_we, cpu_rst_n, busy, done, error} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000", {bus.in_ready, bus.imem_we, cpu_rst_n, busy, done, error});
        else n_pass++;
        n_checks++;
        if (bus.imem_addr !== BASE_ADDR || bus.imem_wdata !== 32'd0 || words_loaded !== '0)
            $display("FAIL reset_values: got addr %h wdata %h count %0d expected %h 0 0",
                     bus.imem_addr, bus.imem_wdata, words_loaded, BASE_ADDR);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] w[$];
        w.push_back(32'h2008_0005);
        w.push_back(32'h0109_5020);
        run_image("basic", 32'd2, w, 0, 32'd0, -1);
    endtask

    task automatic test_toggle();
        logic [31:0] w[$];
        w.push_back(32'h2008_0005);
        w.push_back(32'h0109_5020);
        run_image("toggle", 32'd2, w, 1, 32'd0, -1);
    endtask

    task automatic test_oversize();
        logic [31:0] w[$];
        run_image("oversize", 32'h0000_0101, w, 0, 32'd0, -1);
        run_image("huge_hdr", 32'h0100_0001, w, 2, 32'd0, -1);
    endtask

    task automatic test_zero();
        logic [31:0] w[$];
        run_image("zero", 32'd0, w, 0, 32'd0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        run_image("zero_badsum", 32'd0, w, 0, 32'd1, -1);
`endif
    endtask

    task automatic test_boundary();
        logic [31:0] w[$];
        for (int i = 0; i < int'(DEPTH); i++) w.push_back($urandom);
        run_image("full_depth", 32'(DEPTH), w, 0, 32'd0, -1);
    endtask

    task automatic test_busy_start();
        logic [31:0] w[$];
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        run_image("start_in_header", 32'd3, w, 0, 32'd0, 2);
        run_image("start_in_load", 32'd3, w, 2, 32'd0, 7);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            logic [31:0] w[$];
            int          n;
            logic [31:0] delta;
            n = int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) w.push_back($urandom);
            delta = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 2) == 0) delta = 32'($urandom_range(1, 255));
`endif
            run_image($sformatf("rand%0d", t), 32'(n), w, int'($urandom_range(0, 2)), delta, -1);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0]  q[$];
        logic [31:0] w[$];
        int          base;
        begin_session("mid_reset");
        q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h03);
        q.push_back(8'hde); q.push_back(8'had);
        send_bytes(q, 0, -1);
        bus.in_valid = 1'b0;
        base = got_addr.size();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.imem_we, cpu_rst_n, busy, done, error} !== 6'b0)
            $display("FAIL mid_reset_flags: got %b expected 000000", {bus.in_ready, bus.imem_we, cpu_rst_n, busy, done, error});
        else n_pass++;
        n_checks++;
        if (bus.imem_addr !== BASE_ADDR || bus.imem_wdata !== 32'd0 || words_loaded !== '0)
            $display("FAIL mid_reset_values: got addr %h wdata %h count %0d expected %h 0 0",
                     bus.imem_addr, bus.imem_wdata, words_loaded, BASE_ADDR);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        n_checks++;
        if (got_addr.size() !== base)
            $display("FAIL mid_reset_nowrite: got %0d writes expected 0", got_addr.size() - base);
        else n_pass++;
        w.push_back(32'h8c08_0004);
        run_image("after_reset", 32'd1, w, 0, 32'd0, -1);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] w[$];
        w.push_back(32'h1111_1111);
        w.push_back(32'h2222_2222);
        run_image("csum_ok", 32'd2, w, 0, 32'd0, -1);
        run_image("csum_bad", 32'd2, w, 1, 32'd1, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_oversize();
        test_zero();
        test_boundary();
        test_busy_start();
        test_random();
        test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
